// File: rtl/fxp_dot_accumulator.sv
// Q16.16 dot-product accumulator: sums a stream of signed products per vector
// in a guard-bit-extended accumulator and emits one saturated result per vector
// over a valid/ready handshake, with saturation and overflow-error flags.
module fxp_dot_accumulator #(
  parameter int unsigned GUARD_BITS = 8,
  parameter int unsigned MAX_TERMS  = 256,
  localparam int unsigned CNT_W     = $clog2(MAX_TERMS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      prod_in,
  input  logic             prod_ovf,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      dot_out,
  output logic [CNT_W-1:0] terms_out,
  output logic             sat_flag,
  output logic             err_flag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned ACC_W = 32 + GUARD_BITS;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             beat;
  logic             vec_end;
  logic             in_range;
  logic             sat_d;
  logic [31:0]      dot_d;

  // Held off during reset so no beat can be claimed as accepted on that edge.
  assign in_ready = (state_q == StAccum) && !rst;

  // Next accumulator/count/flag values and the saturated view of the running sum.
  always_comb begin
    beat     = in_valid & in_ready;
    acc_d    = acc_q + {{GUARD_BITS{prod_in[31]}}, prod_in};
    cnt_d    = cnt_q + CNT_W'(1);
    ovf_d    = ovf_q | prod_ovf;
    vec_end  = beat & (in_last | (cnt_d == CNT_W'(MAX_TERMS)));
    // Sum fits in Q16.16 only when every bit from 31 upward equals the sign.
    in_range = (&acc_d[ACC_W-1:31]) | ~(|acc_d[ACC_W-1:31]);
    sat_d    = ~in_range;
    dot_d    = acc_d[31:0];
    if (sat_d) begin
      dot_d = acc_d[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Control FSM, accumulator state and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      dot_out   <= '0;
      terms_out <= '0;
      sat_flag  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (vec_end) begin
            state_q   <= StHold;
            dot_out   <= dot_d;
            sat_flag  <= sat_d;
            err_flag  <= ovf_d;
            terms_out <= cnt_d;
            out_valid <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
          end else if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
          end
        end
        StHold: begin
          // Result fields stay put after the handshake; only valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_dot_accumulator.sv
// Self-checking bench for fxp_dot_accumulator: directed and randomized vectors
// compared against an arithmetic reference model of the vector sum.
module tb_fxp_dot_accumulator;

  localparam int CNT_W  = 9;
  localparam int CNT4_W = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [31:0]       prod_in;
  logic              prod_ovf, in_valid, in_last, in_ready;
  logic [31:0]       dot_out;
  logic [CNT_W-1:0]  terms_out;
  logic              sat_flag, err_flag, out_valid, out_ready;

  logic [31:0]       prod4;
  logic              ovf4, v4, last4, rdy4;
  logic [31:0]       dot4;
  logic [CNT4_W-1:0] terms4;
  logic              sat4, err4, ov4, ordy4;

  fxp_dot_accumulator dut (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_ovf(prod_ovf), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .dot_out(dot_out), .terms_out(terms_out),
    .sat_flag(sat_flag), .err_flag(err_flag), .out_valid(out_valid), .out_ready(out_ready)
  );

  fxp_dot_accumulator #(.GUARD_BITS(8), .MAX_TERMS(4)) dut4 (
    .clk(clk), .rst(rst), .prod_in(prod4), .prod_ovf(ovf4), .in_valid(v4),
    .in_last(last4), .in_ready(rdy4), .dot_out(dot4), .terms_out(terms4),
    .sat_flag(sat4), .err_flag(err4), .out_valid(ov4), .out_ready(ordy4)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]      q_val[$];
  logic             q_ovf[$];
  logic [31:0]      exp_dot;
  logic [CNT_W-1:0] exp_terms;
  logic             exp_sat, exp_err;

  // Reference: exact integer sum, wrapped to the 40-bit accumulator, then clamped.
  function automatic void model();
    longint sum = 0;
    logic [39:0] w;
    longint s;
    exp_err = 1'b0;
    foreach (q_val[i]) begin
      sum = sum + longint'(signed'(q_val[i]));
      exp_err = exp_err | q_ovf[i];
    end
    w = sum[39:0];
    s = longint'(signed'(w));
    exp_sat = (s > MAXV) || (s < MINV);
    if (s > MAXV) exp_dot = 32'h7FFF_FFFF;
    else if (s < MINV) exp_dot = 32'h8000_0000;
    else exp_dot = s[31:0];
    exp_terms = CNT_W'(q_val.size());
  endfunction

  // Stimulus only: present queued beats back to back, in_last on the final one.
  task automatic drive_beats(input bit with_last);
    for (int i = 0; i < q_val.size(); i++) begin
      prod_in  = q_val[i];
      prod_ovf = q_ovf[i];
      in_valid = 1'b1;
      in_last  = with_last && (i == q_val.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    prod_ovf = 1'b0;
  endtask

  task automatic push(input logic [31:0] v, input logic o);
    q_val.push_back(v);
    q_ovf.push_back(o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, dot_out, terms_out, sat_flag, err_flag} !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b dot=%h terms=%0d sat=%b err=%b exp all 0",
               in_ready, out_valid, dot_out, terms_out, sat_flag, err_flag);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    q_val.delete(); q_ovf.delete();
    push(32'h0001_0000, 1'b0); push(32'h0002_0000, 1'b0); push(32'h0000_8000, 1'b0);
    model();
    drive_beats(1'b1);
    checks++;
    if ({out_valid, dot_out, terms_out, sat_flag, err_flag, in_ready} !==
        {1'b1, 32'h0003_8000, CNT_W'(3), 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got vld=%b dot=%h terms=%0d sat=%b err=%b rdy=%b exp 1 00038000 3 0 0 0",
               out_valid, dot_out, terms_out, sat_flag, err_flag, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, dot_out} !== {1'b0, 1'b1, exp_dot}) begin
      failures++;
      $display("FAIL basic_after_hs got vld=%b rdy=%b dot=%h exp 0 1 %h",
               out_valid, in_ready, dot_out, exp_dot);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 2; k++) begin
      q_val.delete(); q_ovf.delete();
      if (k == 0) begin
        push(32'h7FFF_0000, 1'b0); push(32'h7FFF_0000, 1'b0);
      end else begin
        push(32'h8000_0000, 1'b0); push(32'hFFFF_0000, 1'b0);
      end
      model();
      drive_beats(1'b1);
      checks++;
      if ({out_valid, dot_out, terms_out, sat_flag, err_flag} !==
          {1'b1, exp_dot, exp_terms, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL saturation_%0d got vld=%b dot=%h terms=%0d sat=%b err=%b exp 1 %h %0d 1 0",
                 k, out_valid, dot_out, terms_out, sat_flag, err_flag, exp_dot, exp_terms);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_guard();
    q_val.delete(); q_ovf.delete();
    push(32'h7FFF_0000, 1'b0); push(32'h7FFF_0000, 1'b0); push(32'h8001_0000, 1'b0);
    drive_beats(1'b1);
    checks++;
    if ({out_valid, dot_out, terms_out, sat_flag} !== {1'b1, 32'h7FFF_0000, CNT_W'(3), 1'b0}) begin
      failures++;
      $display("FAIL guard_recovery got vld=%b dot=%h terms=%0d sat=%b exp 1 7fff0000 3 0",
               out_valid, dot_out, terms_out, sat_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err_flag();
    for (int k = 0; k < 2; k++) begin
      q_val.delete(); q_ovf.delete();
      if (k == 0) begin
        push(32'h0000_1000, 1'b0); push(32'h0000_2000, 1'b1);
        push(32'h0000_3000, 1'b0); push(32'h0000_4000, 1'b0);
      end else begin
        push(32'h0000_5000, 1'b0); push(32'hFFFF_F000, 1'b0);
      end
      model();
      drive_beats(1'b1);
      checks++;
      if ({out_valid, dot_out, terms_out, sat_flag, err_flag} !==
          {1'b1, exp_dot, exp_terms, exp_sat, (k == 0)}) begin
        failures++;
        $display("FAIL err_flag_%0d got vld=%b dot=%h terms=%0d sat=%b err=%b exp 1 %h %0d %b %b",
                 k, out_valid, dot_out, terms_out, sat_flag, err_flag,
                 exp_dot, exp_terms, exp_sat, (k == 0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    q_val.delete(); q_ovf.delete();
    push($urandom, 1'b0); push($urandom, 1'b1);
    model();
    out_ready = 1'b0;
    drive_beats(1'b1);
    held     = $urandom;
    prod_in  = held;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready, out_valid, dot_out, terms_out, sat_flag, err_flag} !==
          {1'b0, 1'b1, exp_dot, exp_terms, exp_sat, exp_err}) begin
        failures++;
        $display("FAIL backpressure_hold_%0d got rdy=%b vld=%b dot=%h terms=%0d sat=%b err=%b exp 0 1 %h %0d %b %b",
                 c, in_ready, out_valid, dot_out, terms_out, sat_flag, err_flag,
                 exp_dot, exp_terms, exp_sat, exp_err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    q_val.delete(); q_ovf.delete();
    push(held, 1'b0);
    model();
    checks++;
    if ({out_valid, dot_out, terms_out, sat_flag, err_flag} !==
        {1'b1, exp_dot, CNT_W'(1), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL backpressure_held_beat got vld=%b dot=%h terms=%0d sat=%b err=%b exp 1 %h 1 0 0",
               out_valid, dot_out, terms_out, sat_flag, err_flag, exp_dot);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_terms();
    v4 = 1'b1; prod4 = 32'h0001_0000; last4 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({ov4, dot4, terms4, sat4, rdy4} !== {1'b1, 32'h0004_0000, CNT4_W'(4), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL max_terms_result got vld=%b dot=%h terms=%0d sat=%b rdy=%b exp 1 00040000 4 0 0",
               ov4, dot4, terms4, sat4, rdy4);
    end
    @(posedge clk); #1;
    checks++;
    if ({rdy4, ov4} !== 2'b10) begin
      failures++;
      $display("FAIL max_terms_release got rdy=%b vld=%b exp 1 0", rdy4, ov4);
    end
    @(posedge clk); #1;
    prod4 = 32'h0002_0000; last4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; last4 = 1'b0;
    checks++;
    if ({ov4, dot4, terms4} !== {1'b1, 32'h0003_0000, CNT4_W'(2)}) begin
      failures++;
      $display("FAIL max_terms_next_vector got vld=%b dot=%h terms=%0d exp 1 00030000 2",
               ov4, dot4, terms4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    q_val.delete(); q_ovf.delete();
    push($urandom, 1'b1); push($urandom, 1'b0);
    drive_beats(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_val.delete(); q_ovf.delete();
    push($urandom, 1'b0);
    model();
    drive_beats(1'b1);
    checks++;
    if ({out_valid, dot_out, terms_out, sat_flag, err_flag} !==
        {1'b1, exp_dot, CNT_W'(1), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_vector got vld=%b dot=%h terms=%0d sat=%b err=%b exp 1 %h 1 0 0",
               out_valid, dot_out, terms_out, sat_flag, err_flag, exp_dot);
    end
    @(posedge clk); #1;
    // Reset while a result is being held.
    out_ready = 1'b0;
    drive_beats(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, dot_out, terms_out, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_in_hold got vld=%b dot=%h terms=%0d rdy=%b exp all 0",
               out_valid, dot_out, terms_out, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      int len;
      int d;
      logic [31:0] r;
      q_val.delete(); q_ovf.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = $urandom;
        if ($urandom_range(0, 2) != 0) r = {{12{r[19]}}, r[19:0]};
        push(r, ($urandom_range(0, 9) == 0));
      end
      model();
      d = $urandom_range(0, 2);
      out_ready = (d == 0);
      drive_beats(1'b1);
      checks++;
      if ({out_valid, dot_out, terms_out, sat_flag, err_flag, in_ready} !==
          {1'b1, exp_dot, exp_terms, exp_sat, exp_err, 1'b0}) begin
        failures++;
        $display("FAIL random_vec_%0d got vld=%b dot=%h terms=%0d sat=%b err=%b rdy=%b exp 1 %h %0d %b %b 0",
                 n, out_valid, dot_out, terms_out, sat_flag, err_flag, in_ready,
                 exp_dot, exp_terms, exp_sat, exp_err);
      end
      repeat (d) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, dot_out, sat_flag} !== {1'b0, 1'b1, exp_dot, exp_sat}) begin
        failures++;
        $display("FAIL random_hs_%0d got vld=%b rdy=%b dot=%h sat=%b exp 0 1 %h %b",
                 n, out_valid, in_ready, dot_out, sat_flag, exp_dot, exp_sat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    prod_in = '0; prod_ovf = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    prod4 = '0; ovf4 = 1'b0; v4 = 1'b0; last4 = 1'b0; ordy4 = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_guard();
    test_err_flag();
    test_backpressure();
    test_max_terms();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
